// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, XOR-checked byte
// image and writes little-endian 32-bit words to imem, holding the core until verified.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH:0]   WC_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;
  localparam logic [15:0]           MAX_N   = 16'(MAX_WORDS);

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [7:0]            xor_q, xor_d;
  logic [23:0]           buf_q, buf_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  accept;
  logic [15:0]           len_full;

  assign rx_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept     = rx_valid && rx_ready;
  assign len_full   = {rx_data, len_lo_q};
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = word_count_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cpu_hold   = (state_q != S_DONE);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;
    xor_d        = xor_q;
    buf_d        = buf_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN;
          byte_cnt_d   = 2'd0;
          idx_d        = '0;
          word_count_d = '0;
          xor_d        = 8'h00;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            len_lo_d   = rx_data;
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            n_d        = len_full[ADDR_WIDTH:0];
            if (len_full > MAX_N) begin
              state_d = S_ERR;
            end else if (len_full == 16'd0) begin
              state_d = S_CHK;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              // Word complete: the write strobe and address go out next cycle
              we_d         = 1'b1;
              wdata_d      = {rx_data, buf_q};
              addr_d       = {{(30-ADDR_WIDTH){1'b0}}, idx_q, 2'b00};
              idx_d        = idx_q + IDX_ONE;
              word_count_d = word_count_q + WC_ONE;
              if ((word_count_q + WC_ONE) == n_q) begin
                state_d = S_CHK;
              end
            end
          endcase
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      len_lo_q     <= 8'h00;
      n_q          <= '0;
      idx_q        <= '0;
      word_count_q <= '0;
      xor_q        <= 8'h00;
      buf_q        <= 24'h0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
      xor_q        <= xor_d;
      buf_q        <= buf_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams images, scoreboards every imem write
// against words assembled from the stimulus, and checks status/handshake behaviour.
module tb_imem_loader;

  localparam int ADDR_WIDTH = 8;
  localparam int MAX_WORDS  = 256;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                imem_we;
  logic [31:0]         imem_addr;
  logic [31:0]         imem_wdata;
  logic                cpu_hold;
  logic                done;
  logic                error;
  logic [ADDR_WIDTH:0] word_count;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          c0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;
  logic [7:0]  stream[$];
  logic [7:0]  good_img [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};

  imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void check_output(input string tag, input logic [31:0] observed,
                                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endfunction

  // Each write strobe must match the oldest word the stimulus has completed
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      check_output("write_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check_output("write_addr", imem_addr, exp_w[63:32]);
        check_output("write_data", imem_wdata, exp_w[31:0]);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_output({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check_output({tag, "_we"},         32'(imem_we),    32'd0);
    check_output({tag, "_addr"},       imem_addr,       32'd0);
    check_output({tag, "_wdata"},      imem_wdata,      32'd0);
    check_output({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check_output({tag, "_done"},       32'(done),       32'd0);
    check_output({tag, "_error"},      32'(error),      32'd0);
    check_output({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic load_good(input logic [7:0] chk);
    stream.delete();
    foreach (good_img[i]) stream.push_back(good_img[i]);
    stream[10] = chk;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic offer_idle_bytes(input string tag);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output({tag, "_not_ready"}, 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
  endtask

  // Sends stream[first..last]; expected writes are queued before the 4th byte of each word goes out
  task automatic apply_stimulus(input int first, input int last, input int max_gap);
    int  n;
    int  d;
    int  gap;
    int  waits;
    bit  is4th;
    n = int'({stream[1], stream[0]});
    for (int i = first; i <= last; i++) begin
      gap      = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      d     = i - 2;
      is4th = (i >= 2) && (d < 4 * n) && (d % 4 == 3);
      if (is4th && n <= MAX_WORDS) begin
        exp_q.push_back({32'(4 * (d / 4)), stream[i], stream[i-1], stream[i-2], stream[i-3]});
      end
      rx_data  = stream[i];
      rx_valid = 1'b1;
      waits    = 0;
      while (rx_ready !== 1'b1 && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      if (rx_ready !== 1'b1) begin
        check_output("ready_wait", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
      check_output("we_after_byte", 32'(imem_we), is4th ? 32'd1 : 32'd0);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);
    offer_idle_bytes("idle");
    check_output("idle_word_count", 32'(word_count), 32'd0);

    // Valid 2-word image at full rate
    load_good(8'h61);
    c0 = cyc;
    pulse_start();
    check_output("len_rx_ready", 32'(rx_ready), 32'd1);
    apply_stimulus(0, 10, 0);
    check_output("good_done",       32'(done),       32'd1);
    check_output("good_cpu_hold",   32'(cpu_hold),   32'd0);
    check_output("good_error",      32'(error),      32'd0);
    check_output("good_word_count", 32'(word_count), 32'd2);
    check_output("good_rx_ready",   32'(rx_ready),   32'd0);
    check_output("good_cycles",     32'(cyc - c0),   32'd12);
    check_output("hold_addr",       imem_addr,       32'h4);
    check_output("hold_wdata",      imem_wdata,      32'h00108133);

    // Relaunch from DONE with a bad checksum
    pulse_start();
    check_output("relaunch_cpu_hold",   32'(cpu_hold),   32'd1);
    check_output("relaunch_word_count", 32'(word_count), 32'd0);
    check_output("relaunch_done",       32'(done),       32'd0);
    load_good(8'h60);
    apply_stimulus(0, 10, 0);
    check_output("badchk_error",      32'(error),      32'd1);
    check_output("badchk_cpu_hold",   32'(cpu_hold),   32'd1);
    check_output("badchk_done",       32'(done),       32'd0);
    check_output("badchk_word_count", 32'(word_count), 32'd2);

    // Empty image
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    pulse_start();
    check_output("empty_error_cleared", 32'(error), 32'd0);
    apply_stimulus(0, 2, 0);
    check_output("empty_done",       32'(done),       32'd1);
    check_output("empty_word_count", 32'(word_count), 32'd0);

    // Oversize length
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h01);
    pulse_start();
    apply_stimulus(0, 1, 0);
    check_output("oversize_error",    32'(error),    32'd1);
    check_output("oversize_rx_ready", 32'(rx_ready), 32'd0);
    check_output("oversize_done",     32'(done),     32'd0);

    // Gapped valid, then bytes offered in DONE
    load_good(8'h61);
    pulse_start();
    apply_stimulus(0, 10, 3);
    check_output("gapped_done",       32'(done),       32'd1);
    check_output("gapped_word_count", 32'(word_count), 32'd2);
    offer_idle_bytes("done");
    check_output("done_still_done",  32'(done),       32'd1);
    check_output("done_word_count",  32'(word_count), 32'd2);

    // Reset asserted mid-DATA after 6 bytes, then a full reload
    pulse_start();
    apply_stimulus(0, 5, 0);
    #2 reset = 1'b0;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    check_reset_state("held_reset");
    reset = 1'b1;
    @(negedge clk);
    check_output("post_reset_idle", 32'(rx_ready), 32'd0);
    pulse_start();
    apply_stimulus(0, 10, 0);
    check_output("reload_done",       32'(done),       32'd1);
    check_output("reload_word_count", 32'(word_count), 32'd2);

    // start pulsed mid-DATA is ignored
    pulse_start();
    apply_stimulus(0, 3, 0);
    pulse_start();
    check_output("midstart_rx_ready",   32'(rx_ready),   32'd1);
    check_output("midstart_word_count", 32'(word_count), 32'd0);
    apply_stimulus(4, 10, 0);
    check_output("midstart_done",       32'(done),       32'd1);
    check_output("midstart_final_wc",   32'(word_count), 32'd2);

    repeat (2) @(negedge clk);
    check_output("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
